// File: rtl/case_7_sdiv_13s_13s_13_seq_pkg.sv
// rtl/case_7_sdiv_13s_13s_13_seq_pkg.sv - shared constants for the case_7 sequential signed divider
package case_7_sdiv_13s_13s_13_seq_pkg;

   localparam int W     = 13;
   localparam int CNT_W = $clog2(W);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/case_7_sdiv_13s_13s_13_seq_step.sv
// rtl/case_7_sdiv_13s_13s_13_seq_step.sv - one combinational restoring division iteration
module case_7_sdiv_13s_13s_13_seq_step
   import case_7_sdiv_13s_13s_13_seq_pkg::*;
(
   input  logic [W:0]   i_rem_in,
   input  logic         i_dividend_bit,
   input  logic [W-1:0] i_divisor,
   output logic [W:0]   o_rem_out,
   output logic         o_q_bit
);

   logic [W:0]   w_shift;
   logic [W+1:0] w_diff;

   assign w_shift = {i_rem_in[W-1:0], i_dividend_bit};
   assign w_diff  = {1'b0, w_shift} - {2'b00, i_divisor};

   // A set top bit means the true shifted value exceeds any W-bit divisor.
   assign o_q_bit   = i_rem_in[W] | ~w_diff[W+1];
   assign o_rem_out = o_q_bit ? w_diff[W:0] : w_shift;

endmodule

// File: rtl/case_7_sdiv_13s_13s_13_seq.sv
// rtl/case_7_sdiv_13s_13s_13_seq.sv - multi-cycle signed divider with start/done/ce handshake
module case_7_sdiv_13s_13s_13_seq
   import case_7_sdiv_13s_13s_13_seq_pkg::*;
#(
   parameter int ID         = 1,
   parameter int din0_WIDTH = 13,
   parameter int din1_WIDTH = 13,
   parameter int dout_WIDTH = 13
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  ready,
   output logic                  done,
   output logic [dout_WIDTH-1:0] quot,
   output logic [dout_WIDTH-1:0] rem,
   output logic                  div_by_zero
);

   if (din0_WIDTH != W || din1_WIDTH != W || dout_WIDTH != W || ID < 0) begin : g_param_check
      $error("case_7_sdiv_13s_13s_13_seq: unsupported width parameters");
   end

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_last;
   logic [W-1:0]     r_dvd;
   logic [W-1:0]     r_dsr;
   logic [W:0]       r_prem;
   logic             r_sign_q;
   logic             r_sign_r;
   logic             r_zero;
   logic [W-1:0]     r_din0;
   logic [W-1:0]     r_quot;
   logic [W-1:0]     r_rem;
   logic             r_done;
   logic             r_dbz;

   logic [W-1:0]     w_a_mag;
   logic [W-1:0]     w_b_mag;
   logic [W:0]       w_step_rem;
   logic             w_step_q;
   logic [W-1:0]     w_quot_fix;
   logic [W-1:0]     w_rem_fix;

   // |-4096| = 0x1000 is representable as a W-bit unsigned magnitude.
   assign w_a_mag = din0[W-1] ? -din0 : din0;
   assign w_b_mag = din1[W-1] ? -din1 : din1;

   case_7_sdiv_13s_13s_13_seq_step u_step (
      .i_rem_in       (r_prem),
      .i_dividend_bit (r_dvd[W-1]),
      .i_divisor      (r_dsr),
      .o_rem_out      (w_step_rem),
      .o_q_bit        (w_step_q)
   );

   // r_dvd shifts the dividend out at the top and the quotient in at the bottom.
   assign w_quot_fix = r_zero ? {W{1'b1}} : (r_sign_q ? -r_dvd : r_dvd);
   assign w_rem_fix  = r_zero ? r_din0 : (r_sign_r ? -r_prem[W-1:0] : r_prem[W-1:0]);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_last   <= 1'b0;
         r_dvd    <= '0;
         r_dsr    <= '0;
         r_prem   <= '0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_zero   <= 1'b0;
         r_din0   <= '0;
         r_quot   <= '0;
         r_rem    <= '0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
      end else if (ce) begin
         case (r_state)
            ST_CALC: begin
               if (r_last) begin
                  r_quot  <= w_quot_fix;
                  r_rem   <= w_rem_fix;
                  r_dbz   <= r_zero;
                  r_done  <= 1'b1;
                  r_last  <= 1'b0;
                  r_state <= ST_DONE;
               end else begin
                  r_prem <= w_step_rem;
                  r_dvd  <= {r_dvd[W-2:0], w_step_q};
                  if (r_cnt == '0) begin
                     r_last <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
            end
            default: begin
               r_done <= 1'b0;
               if (start) begin
                  r_dvd    <= w_a_mag;
                  r_dsr    <= w_b_mag;
                  r_din0   <= din0;
                  r_sign_q <= din0[W-1] ^ din1[W-1];
                  r_sign_r <= din0[W-1];
                  r_zero   <= (din1 == '0);
                  r_prem   <= '0;
                  r_cnt    <= CNT_W'(W-1);
                  r_last   <= 1'b0;
                  r_state  <= ST_CALC;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign ready       = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign done        = r_done;
   assign quot        = r_quot;
   assign rem         = r_rem;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_case_7_sdiv_13s_13s_13_seq.sv
// tb/tb_case_7_sdiv_13s_13s_13_seq.sv - directed self-checking bench for the sequential signed divider
module tb_case_7_sdiv_13s_13s_13_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic        start;
   logic [12:0] din0;
   logic [12:0] din1;
   logic        ready;
   logic        done;
   logic [12:0] quot;
   logic [12:0] rem;
   logic        div_by_zero;

   int n_cmp = 0;
   int n_err = 0;

   case_7_sdiv_13s_13s_13_seq #(
      .ID         (1),
      .din0_WIDTH (13),
      .din1_WIDTH (13),
      .dout_WIDTH (13)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ce          (ce),
      .start       (start),
      .din0        (din0),
      .din1        (din1),
      .ready       (ready),
      .done        (done),
      .quot        (quot),
      .rem         (rem),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   // Issues one division and waits for done; operands are scrambled after the start edge.
   task automatic run_div(input logic [12:0] a, input logic [12:0] b,
                          output logic [12:0] q, output logic [12:0] r, output logic z,
                          output int lat, output logic rdy_seen);
      start = 1'b1; din0 = a; din1 = b;
      step_clk();
      start = 1'b0; din0 = 13'h0AAA; din1 = 13'h0003;
      lat = 0; rdy_seen = 1'b0;
      while (!done && lat < 40) begin
         if (ready) rdy_seen = 1'b1;
         step_clk();
         lat++;
      end
      q = quot; r = rem; z = div_by_zero;
      if (!done) lat = 999;
   endtask

   task automatic test_reset();
      reset = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
      step_clk(); step_clk();
      n_cmp++; if (quot !== 13'h0000) begin n_err++; $display("FAIL reset_quot got=%h exp=%h", quot, 13'h0000); end
      n_cmp++; if (rem !== 13'h0000) begin n_err++; $display("FAIL reset_rem got=%h exp=%h", rem, 13'h0000); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready); end
      reset = 1'b0;
      step_clk();
   endtask

   task automatic test_basic();
      logic [12:0] q, r; logic z, rs; int lat;
      run_div(13'd100, 13'd7, q, r, z, lat, rs);
      n_cmp++; if (q !== 13'h000E) begin n_err++; $display("FAIL basic_quot got=%h exp=%h", q, 13'h000E); end
      n_cmp++; if (r !== 13'h0002) begin n_err++; $display("FAIL basic_rem got=%h exp=%h", r, 13'h0002); end
      n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL basic_dbz got=%b exp=0", z); end
      n_cmp++; if (lat !== 14) begin n_err++; $display("FAIL basic_latency got=%0d exp=14", lat); end
      n_cmp++; if (rs !== 1'b0) begin n_err++; $display("FAIL basic_ready_in_calc got=%b exp=0", rs); end
      step_clk();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
      n_cmp++; if (quot !== 13'h000E) begin n_err++; $display("FAIL basic_quot_hold got=%h exp=%h", quot, 13'h000E); end
   endtask

   task automatic test_signs();
      logic [12:0] ta[3], tb[3], eq[3], er[3];
      logic [12:0] q, r; logic z, rs; int lat;
      ta[0] = 13'h1F9C; tb[0] = 13'h0007; eq[0] = 13'h1FF2; er[0] = 13'h1FFE;
      ta[1] = 13'h0064; tb[1] = 13'h1FF9; eq[1] = 13'h1FF2; er[1] = 13'h0002;
      ta[2] = 13'h1F9C; tb[2] = 13'h1FF9; eq[2] = 13'h000E; er[2] = 13'h1FFE;
      for (int i = 0; i < 3; i++) begin
         run_div(ta[i], tb[i], q, r, z, lat, rs);
         n_cmp++; if (q !== eq[i]) begin n_err++; $display("FAIL sign%0d_quot got=%h exp=%h", i, q, eq[i]); end
         n_cmp++; if (r !== er[i]) begin n_err++; $display("FAIL sign%0d_rem got=%h exp=%h", i, r, er[i]); end
         n_cmp++; if (lat !== 14) begin n_err++; $display("FAIL sign%0d_latency got=%0d exp=14", i, lat); end
      end
   endtask

   task automatic test_edges();
      logic [12:0] ta[3], tb[3], eq[3], er[3];
      logic [12:0] q, r; logic z, rs; int lat;
      ta[0] = 13'h1000; tb[0] = 13'h1FFF; eq[0] = 13'h1000; er[0] = 13'h0000;
      ta[1] = 13'h0FFF; tb[1] = 13'h0001; eq[1] = 13'h0FFF; er[1] = 13'h0000;
      ta[2] = 13'h0005; tb[2] = 13'h0FFF; eq[2] = 13'h0000; er[2] = 13'h0005;
      for (int i = 0; i < 3; i++) begin
         run_div(ta[i], tb[i], q, r, z, lat, rs);
         n_cmp++; if (q !== eq[i]) begin n_err++; $display("FAIL edge%0d_quot got=%h exp=%h", i, q, eq[i]); end
         n_cmp++; if (r !== er[i]) begin n_err++; $display("FAIL edge%0d_rem got=%h exp=%h", i, r, er[i]); end
         n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL edge%0d_dbz got=%b exp=0", i, z); end
      end
   endtask

   task automatic test_div_zero();
      logic [12:0] q, r; logic z, rs; int lat;
      run_div(13'd57, 13'd0, q, r, z, lat, rs);
      n_cmp++; if (q !== 13'h1FFF) begin n_err++; $display("FAIL dz_quot got=%h exp=%h", q, 13'h1FFF); end
      n_cmp++; if (r !== 13'h0039) begin n_err++; $display("FAIL dz_rem got=%h exp=%h", r, 13'h0039); end
      n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL dz_flag got=%b exp=1", z); end
      n_cmp++; if (lat !== 14) begin n_err++; $display("FAIL dz_latency got=%0d exp=14", lat); end
      run_div(13'd9, 13'd3, q, r, z, lat, rs);
      n_cmp++; if (q !== 13'h0003) begin n_err++; $display("FAIL dz_next_quot got=%h exp=%h", q, 13'h0003); end
      n_cmp++; if (r !== 13'h0000) begin n_err++; $display("FAIL dz_next_rem got=%h exp=%h", r, 13'h0000); end
      n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL dz_next_flag got=%b exp=0", z); end
   endtask

   task automatic test_stall();
      int lat;
      start = 1'b1; din0 = 13'd100; din1 = 13'd7;
      step_clk();
      start = 1'b0; lat = 0;
      while (!done && lat < 60) begin
         ce = (lat >= 5 && lat < 10) ? 1'b0 : 1'b1;
         step_clk();
         lat++;
      end
      ce = 1'b1;
      n_cmp++; if (lat !== 19) begin n_err++; $display("FAIL stall_latency got=%0d exp=19", lat); end
      n_cmp++; if (quot !== 13'h000E) begin n_err++; $display("FAIL stall_quot got=%h exp=%h", quot, 13'h000E); end
      n_cmp++; if (rem !== 13'h0002) begin n_err++; $display("FAIL stall_rem got=%h exp=%h", rem, 13'h0002); end
      ce = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step_clk();
         n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_done_stretch%0d got=%b exp=1", i, done); end
      end
      ce = 1'b1;
      step_clk();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL stall_done_release got=%b exp=0", done); end
      n_cmp++; if (quot !== 13'h000E) begin n_err++; $display("FAIL stall_quot_hold got=%h exp=%h", quot, 13'h000E); end
   endtask

   task automatic test_reset_mid();
      logic seen;
      start = 1'b1; din0 = 13'd100; din1 = 13'd7;
      step_clk();
      start = 1'b0;
      repeat (6) step_clk();
      reset = 1'b1;
      step_clk();
      n_cmp++; if (quot !== 13'h0000) begin n_err++; $display("FAIL rstmid_quot got=%h exp=%h", quot, 13'h0000); end
      n_cmp++; if (rem !== 13'h0000) begin n_err++; $display("FAIL rstmid_rem got=%h exp=%h", rem, 13'h0000); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got=%b exp=0", done); end
      reset = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         step_clk();
         if (done) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done got=%b exp=0", seen); end
   endtask

   task automatic test_start_ignored();
      int lat; logic seen;
      start = 1'b1; din0 = 13'd100; din1 = 13'd7;
      step_clk();
      start = 1'b0; lat = 0;
      while (!done && lat < 40) begin
         start = (lat >= 2 && lat <= 9) ? 1'b1 : 1'b0;
         din0 = 13'd50; din1 = 13'd5;
         step_clk();
         lat++;
      end
      start = 1'b0;
      n_cmp++; if (lat !== 14) begin n_err++; $display("FAIL ign_latency got=%0d exp=14", lat); end
      n_cmp++; if (quot !== 13'h000E) begin n_err++; $display("FAIL ign_quot got=%h exp=%h", quot, 13'h000E); end
      n_cmp++; if (rem !== 13'h0002) begin n_err++; $display("FAIL ign_rem got=%h exp=%h", rem, 13'h0002); end
      seen = 1'b0;
      repeat (16) begin
         step_clk();
         if (done) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL ign_no_queued_done got=%b exp=0", seen); end
   endtask

   task automatic test_back_to_back();
      int d[4]; int n;
      n = 0;
      start = 1'b1; din0 = 13'h1F9C; din1 = 13'd7;
      for (int c = 1; c <= 50; c++) begin
         step_clk();
         if (done) begin
            if (n < 4) d[n] = c;
            n++;
            n_cmp++; if (quot !== 13'h1FF2) begin n_err++; $display("FAIL b2b_quot got=%h exp=%h", quot, 13'h1FF2); end
            n_cmp++; if (rem !== 13'h1FFE) begin n_err++; $display("FAIL b2b_rem got=%h exp=%h", rem, 13'h1FFE); end
         end
      end
      start = 1'b0;
      n_cmp++; if (n !== 3) begin n_err++; $display("FAIL b2b_count got=%0d exp=3", n); end
      if (n >= 3) begin
         n_cmp++; if (d[0] !== 15) begin n_err++; $display("FAIL b2b_first got=%0d exp=15", d[0]); end
         n_cmp++; if (d[1] - d[0] !== 15) begin n_err++; $display("FAIL b2b_gap1 got=%0d exp=15", d[1] - d[0]); end
         n_cmp++; if (d[2] - d[1] !== 15) begin n_err++; $display("FAIL b2b_gap2 got=%0d exp=15", d[2] - d[1]); end
      end
      repeat (20) step_clk();
   endtask

   initial begin
      reset = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
      test_reset();
      test_basic();
      test_signs();
      test_edges();
      test_div_zero();
      test_stall();
      test_reset_mid();
      test_start_ignored();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
